// File: rtl/sc_backg_sequencer_if.sv
// Control bundle between the game FSM, the background sequencer and the
// background-type row register. Signal names match the original flat ports.
interface sc_backg_sequencer_if;
    logic       SC_BACKGSEQ_start_InLow;
    logic       SC_BACKGSEQ_levelup_InLow;
    logic       SC_BACKGSEQ_pause_InLow;
    logic       SC_BACKGSEQ_clear_OutLow;
    logic       SC_BACKGSEQ_load_OutLow;
    logic [1:0] SC_BACKGSEQ_shiftselection_Out;
    logic [2:0] SC_BACKGSEQ_transitioncounter_OutBUS;
    logic       SC_BACKGSEQ_run_Out;

    // Game-FSM side: issues start / level-up / pause, observes register controls.
    modport master (
        output SC_BACKGSEQ_start_InLow,
        output SC_BACKGSEQ_levelup_InLow,
        output SC_BACKGSEQ_pause_InLow,
        input  SC_BACKGSEQ_clear_OutLow,
        input  SC_BACKGSEQ_load_OutLow,
        input  SC_BACKGSEQ_shiftselection_Out,
        input  SC_BACKGSEQ_transitioncounter_OutBUS,
        input  SC_BACKGSEQ_run_Out
    );

    // Sequencer side.
    modport slave (
        input  SC_BACKGSEQ_start_InLow,
        input  SC_BACKGSEQ_levelup_InLow,
        input  SC_BACKGSEQ_pause_InLow,
        output SC_BACKGSEQ_clear_OutLow,
        output SC_BACKGSEQ_load_OutLow,
        output SC_BACKGSEQ_shiftselection_Out,
        output SC_BACKGSEQ_transitioncounter_OutBUS,
        output SC_BACKGSEQ_run_Out
    );
endinterface

// File: rtl/sc_backg_sequencer.sv
// Background-type register sequencer: drives clear/load/shift of the row
// register, owns the level counter and paces scrolling with a prescaler
// whose period halves on every level.
module sc_backg_sequencer #(
    parameter int unsigned                PRESCALER_WIDTH = 24,
    parameter logic [PRESCALER_WIDTH-1:0] BASE_PERIOD     = 24'd12_500_000,
    parameter logic [1:0]                 SHIFT_DIR       = 2'b01,
    parameter logic [2:0]                 MAX_LEVEL       = 3'd3
) (
    input logic                 SC_BACKGSEQ_CLOCK_50,
    input logic                 SC_BACKGSEQ_RESET_InHigh,
    sc_backg_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       clear_n_q, clear_n_d;
    logic                       load_n_q, load_n_d;
    logic [1:0]                 shift_q, shift_d;
    logic [2:0]                 level_q, level_d;
    logic                       run_q, run_d;
    logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
    logic                       lvl_hist_q, lvl_hist_d;

    logic [PRESCALER_WIDTH-1:0] period_m1;
    logic                       levelup_edge;

    // Terminal prescaler count for the current level and level-up 1->0 event.
    always_comb begin
        period_m1    = (BASE_PERIOD >> level_q) - PRESCALER_WIDTH'(1);
        levelup_edge = lvl_hist_q & ~bus.SC_BACKGSEQ_levelup_InLow;
    end

    // Next-state and next-output logic; every output is registered, so each
    // branch computes the control values belonging to the state being entered.
    always_comb begin
        state_d    = state_q;
        clear_n_d  = 1'b1;
        load_n_d   = 1'b1;
        shift_d    = '0;
        level_d    = level_q;
        run_d      = 1'b0;
        presc_d    = presc_q;
        lvl_hist_d = bus.SC_BACKGSEQ_levelup_InLow;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!bus.SC_BACKGSEQ_start_InLow) begin
                    state_d   = ST_CLEAR;
                    clear_n_d = 1'b0;
                    level_d   = '0;
                end
            end
            ST_CLEAR: begin
                state_d  = ST_LOAD;
                load_n_d = 1'b0;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                run_d   = 1'b1;
                presc_d = '0;
            end
            ST_RUN: begin
                // Restart beats level-up, level-up beats a due tick (tick dropped).
                if (!bus.SC_BACKGSEQ_start_InLow) begin
                    state_d   = ST_CLEAR;
                    clear_n_d = 1'b0;
                    level_d   = '0;
                end else if (levelup_edge) begin
                    state_d = (level_q < MAX_LEVEL) ? ST_NEXT : ST_DONE;
                end else begin
                    run_d = 1'b1;
                    if (bus.SC_BACKGSEQ_pause_InLow) begin
                        if (presc_q == period_m1) begin
                            shift_d = SHIFT_DIR;
                            presc_d = '0;
                        end else begin
                            presc_d = presc_q + PRESCALER_WIDTH'(1);
                        end
                    end
                end
            end
            ST_NEXT: begin
                state_d  = ST_LOAD;
                load_n_d = 1'b0;
                level_d  = level_q + 3'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and counter registers with asynchronous reset.
    always_ff @(posedge SC_BACKGSEQ_CLOCK_50 or posedge SC_BACKGSEQ_RESET_InHigh) begin
        if (SC_BACKGSEQ_RESET_InHigh) begin
            state_q    <= ST_IDLE;
            clear_n_q  <= 1'b1;
            load_n_q   <= 1'b1;
            shift_q    <= '0;
            level_q    <= '0;
            run_q      <= 1'b0;
            presc_q    <= '0;
            lvl_hist_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clear_n_q  <= clear_n_d;
            load_n_q   <= load_n_d;
            shift_q    <= shift_d;
            level_q    <= level_d;
            run_q      <= run_d;
            presc_q    <= presc_d;
            lvl_hist_q <= lvl_hist_d;
        end
    end

    assign bus.SC_BACKGSEQ_clear_OutLow             = clear_n_q;
    assign bus.SC_BACKGSEQ_load_OutLow              = load_n_q;
    assign bus.SC_BACKGSEQ_shiftselection_Out       = shift_q;
    assign bus.SC_BACKGSEQ_transitioncounter_OutBUS = level_q;
    assign bus.SC_BACKGSEQ_run_Out                  = run_q;

endmodule
